// File: rtl/buffered_fanout_tree_pkg.sv
// Shared sizing helpers for the registered fanout tree.
// Level count, copies per level and parent mapping are all derived here.
package buffered_fanout_tree_pkg;

    function automatic int unsigned pow_f(input int unsigned f, input int unsigned e);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < e; i++) p = p * f;
        return p;
    endfunction

    // ceil(log_f(n)), never below 1
    function automatic int unsigned clog_f(input int unsigned n, input int unsigned f);
        int unsigned r;
        int unsigned p;
        r = 1;
        p = f;
        while (p < n) begin
            p = p * f;
            r = r + 1;
        end
        return r;
    endfunction

    // copies at level k of an l-level tree; k = 0 is the single source
    function automatic int unsigned copies(input int unsigned n, input int unsigned f,
                                           input int unsigned l, input int unsigned k);
        int unsigned s;
        s = pow_f(f, l - k);
        return (n + s - 1) / s;
    endfunction

    function automatic int unsigned parent(input int unsigned j, input int unsigned f);
        return j / f;
    endfunction

endpackage

// File: rtl/buffered_fanout_tree_if.sv
// Producer/consumer bundle of the fanout tree: one source port, N_OUT sink ports.
interface buffered_fanout_tree_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_OUT = 20
) ();
    import buffered_fanout_tree_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [N_OUT-1:0]       in_mask;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   busy;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/fanout_tree_level.sv
// One register level of the tree: NC copies of {valid, data, mask slice},
// each fed by its parent copy, all advancing together on adv.
module fanout_tree_level
    import buffered_fanout_tree_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FANOUT = 5,
    parameter int unsigned NP     = 1,
    parameter int unsigned NC     = 4,
    parameter int unsigned SPAN   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    input  logic [NP-1:0]         up_valid,
    input  logic [NP*WIDTH-1:0]   up_data,
    input  logic [NC*SPAN-1:0]    up_mask,
    output logic [NC-1:0]         valid,
    output logic [NC*WIDTH-1:0]   data,
    output logic [NC*SPAN-1:0]    mask
);

    // Copy j owns sinks [j*SPAN, j*SPAN+SPAN-1], which is exactly the same
    // bit range of the parent-level mask vector, so the mask copies straight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            data  <= '0;
            mask  <= '0;
        end else if (adv) begin
            for (int unsigned j = 0; j < NC; j++) begin
                valid[j]                <= up_valid[parent(j, FANOUT)];
                data[j*WIDTH +: WIDTH]  <= up_data[parent(j, FANOUT)*WIDTH +: WIDTH];
            end
            mask <= up_mask;
        end
    end

endmodule

// File: rtl/buffered_fanout_tree.sv
// Registered fanout tree: broadcasts one token stream to N_OUT sinks through
// L register levels, ending in an eager fork with per-sink handshakes.
module buffered_fanout_tree
    import buffered_fanout_tree_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N_OUT      = 20,
    parameter int unsigned MAX_FANOUT = 5,
    parameter bit          INVERT     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    buffered_fanout_tree_if.slave   bus
);

    localparam int unsigned L  = clog_f(N_OUT, MAX_FANOUT);
    localparam int unsigned MW = pow_f(MAX_FANOUT, L);

    // Index 0 is the source port viewed as a one-copy level.
    logic [N_OUT-1:0]       lvl_valid [L+1];
    logic [N_OUT*WIDTH-1:0] lvl_data  [L+1];
    logic [MW-1:0]          lvl_mask  [L+1];
    logic [L-1:0]           lvl_busy;

    logic [N_OUT-1:0] acked;
    logic [N_OUT-1:0] pending;
    logic             adv;

    assign lvl_valid[0] = N_OUT'(bus.in_valid);
    assign lvl_data[0]  = (N_OUT*WIDTH)'(bus.in_data);
    assign lvl_mask[0]  = MW'(bus.in_mask);

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int unsigned NC   = copies(N_OUT, MAX_FANOUT, L, k);
        localparam int unsigned NP   = copies(N_OUT, MAX_FANOUT, L, k - 1);
        localparam int unsigned SPAN = pow_f(MAX_FANOUT, L - k);

        fanout_tree_level #(
            .WIDTH  (WIDTH),
            .FANOUT (MAX_FANOUT),
            .NP     (NP),
            .NC     (NC),
            .SPAN   (SPAN)
        ) u_level (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .up_valid (lvl_valid[k-1][NP-1:0]),
            .up_data  (lvl_data[k-1][NP*WIDTH-1:0]),
            .up_mask  (lvl_mask[k-1][NC*SPAN-1:0]),
            .valid    (lvl_valid[k][NC-1:0]),
            .data     (lvl_data[k][NC*WIDTH-1:0]),
            .mask     (lvl_mask[k][NC*SPAN-1:0])
        );

        if (NC < N_OUT) begin : g_pad
            assign lvl_valid[k][N_OUT-1:NC]             = '0;
            assign lvl_data[k][N_OUT*WIDTH-1:NC*WIDTH] = '0;
        end
        if (NC * SPAN < MW) begin : g_mpad
            assign lvl_mask[k][MW-1:NC*SPAN] = '0;
        end

        assign lvl_busy[k-1] = |lvl_valid[k][NC-1:0];
    end

    // A sink that already took the leaf token stays quiet until the tree advances.
    always_comb begin
        pending = '0;
        pending = lvl_valid[L] & lvl_mask[L][N_OUT-1:0] & ~acked;
    end

    assign adv = &(~pending | bus.out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acked <= '0;
        end else if (adv) begin
            acked <= '0;
        end else begin
            acked <= acked | (pending & bus.out_ready);
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = pending;
    assign bus.out_data  = INVERT ? ~lvl_data[L] : lvl_data[L];
    assign bus.busy      = |lvl_busy;

endmodule

// File: tb/tb_buffered_fanout_tree.sv
// Self-checking bench for buffered_fanout_tree: directed scenarios plus a
// per-sink scoreboard fed on every accepted token.
module tb_buffered_fanout_tree;

    localparam int unsigned W = 8;
    localparam int unsigned N = 20;
    localparam logic [N-1:0] ALL = {N{1'b1}};

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    logic [W-1:0] sbq [N][$];

    always #5 clk = ~clk;

    buffered_fanout_tree_if #(.WIDTH(W), .N_OUT(N)) bus ();
    buffered_fanout_tree_if #(.WIDTH(W), .N_OUT(1)) sbus ();

    buffered_fanout_tree #(.WIDTH(W), .N_OUT(N), .MAX_FANOUT(5), .INVERT(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    buffered_fanout_tree #(.WIDTH(W), .N_OUT(1), .MAX_FANOUT(2), .INVERT(1'b0)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    task automatic settle();
        #4;
    endtask

    // Scoreboard sample (just before the edge), then move to the next negedge.
    task automatic advance();
        logic [W-1:0] e;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.out_valid[i] && bus.out_ready[i]) begin
                vecs++;
                if (sbq[i].size() == 0) begin
                    errs++;
                    $display("FAIL sb_extra sink %0d got %h, none expected", i, bus.out_data[i*W +: W]);
                end else begin
                    e = sbq[i].pop_front();
                    if (bus.out_data[i*W +: W] !== e) begin
                        errs++;
                        $display("FAIL sb_data sink %0d got %h exp %h", i, bus.out_data[i*W +: W], e);
                    end
                end
            end
        end
        if (bus.in_valid && bus.in_ready)
            for (int i = 0; i < int'(N); i++)
                if (bus.in_mask[i]) sbq[i].push_back(~bus.in_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = ALL;
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL rst_valid got %h exp 0", bus.out_valid); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", bus.in_ready); end
        vecs++; if (bus.out_data !== {N*W{1'b1}}) begin errs++; $display("FAIL rst_data got %h exp all-1", bus.out_data); end
        vecs++; if (sbus.out_data !== 8'h00) begin errs++; $display("FAIL rst_small_data got %h exp 00", sbus.out_data); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain(2);
    endtask

    task automatic test_single();
        logic [N-1:0] exp_v [4];
        exp_v = '{20'h0, 20'h0, 20'hFFFFF, 20'h0};
        for (int c = 0; c < 4; c++) begin
            bus.in_valid  = (c == 0);
            bus.in_data   = 8'hA5;
            bus.in_mask   = ALL;
            bus.out_ready = ALL;
            settle();
            vecs++;
            if (bus.out_valid !== exp_v[c]) begin
                errs++; $display("FAIL single_valid cyc %0d got %h exp %h", c, bus.out_valid, exp_v[c]);
            end
            if (c == 2)
                for (int i = 0; i < int'(N); i++) begin
                    vecs++;
                    if (bus.out_data[i*W +: W] !== 8'h5A) begin
                        errs++; $display("FAIL single_data sink %0d got %h exp 5a", i, bus.out_data[i*W +: W]);
                    end
                end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] src [3];
        logic [N-1:0] exp_v [9];
        logic         exp_r [9];
        int idx = 0;
        src   = '{8'h01, 8'h02, 8'h03};
        exp_v = '{20'h0, 20'h0, 20'hFFFFF, 20'h00080, 20'h00080, 20'h00080, 20'hFFFFF, 20'hFFFFF, 20'h0};
        exp_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 9; c++) begin
            bus.in_valid  = (idx < 3);
            bus.in_data   = src[idx < 3 ? idx : 2];
            bus.in_mask   = ALL;
            bus.out_ready = (c >= 2 && c <= 4) ? ~(N'(1) << 7) : ALL;
            settle();
            vecs++;
            if (bus.out_valid !== exp_v[c]) begin
                errs++; $display("FAIL stall_valid cyc %0d got %h exp %h", c, bus.out_valid, exp_v[c]);
            end
            vecs++;
            if (bus.in_ready !== exp_r[c]) begin
                errs++; $display("FAIL stall_ready cyc %0d got %b exp %b", c, bus.in_ready, exp_r[c]);
            end
            if (c >= 2 && c <= 5) begin
                vecs++;
                if (bus.out_data[7*W +: W] !== 8'hFE) begin
                    errs++; $display("FAIL stall_hold cyc %0d got %h exp fe", c, bus.out_data[7*W +: W]);
                end
            end
            if (bus.in_valid && bus.in_ready) idx++;
            advance();
        end
    endtask

    task automatic test_mask();
        logic [N-1:0] exp_v [5];
        logic         exp_b [5];
        exp_v = '{20'h0, 20'h0, 20'h00001, 20'h0, 20'h0};
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            bus.in_valid  = (c < 2);
            bus.in_data   = (c == 0) ? 8'h33 : 8'h44;
            bus.in_mask   = (c == 0) ? N'(1) : '0;
            bus.out_ready = ALL;
            settle();
            vecs++;
            if (bus.out_valid !== exp_v[c]) begin
                errs++; $display("FAIL mask_valid cyc %0d got %h exp %h", c, bus.out_valid, exp_v[c]);
            end
            vecs++;
            if (bus.busy !== exp_b[c]) begin
                errs++; $display("FAIL mask_busy cyc %0d got %b exp %b", c, bus.busy, exp_b[c]);
            end
            if (c == 2) begin
                vecs++;
                if (bus.out_data[0 +: W] !== 8'hCC) begin
                    errs++; $display("FAIL mask_data got %h exp cc", bus.out_data[0 +: W]);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 4; c++) begin
            bus.in_valid  = (c < 2);
            bus.in_data   = (c == 0) ? 8'h11 : 8'h22;
            bus.in_mask   = ALL;
            bus.out_ready = ~(N'(1) << 3);
            settle();
            if (c == 3) begin
                vecs++;
                if (bus.out_valid !== (N'(1) << 3) || bus.busy !== 1'b1) begin
                    errs++; $display("FAIL midrst_pre got valid %h busy %b exp 00008 1", bus.out_valid, bus.busy);
                end
            end
            advance();
        end
        #1;
        rst = 1'b1;
        #1;
        vecs++; if (bus.out_valid !== '0) begin errs++; $display("FAIL midrst_valid got %h exp 0", bus.out_valid); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready got %b exp 1", bus.in_ready); end
        for (int i = 0; i < int'(N); i++) sbq[i].delete();
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = ALL;
        for (int c = 0; c < 5; c++) begin
            settle();
            vecs++;
            if (bus.out_valid !== '0 || bus.busy !== 1'b0) begin
                errs++; $display("FAIL midrst_stale cyc %0d got valid %h busy %b exp 0 0", c, bus.out_valid, bus.busy);
            end
            advance();
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc  = 0;
        bus.in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = W'($urandom);
                case ($urandom_range(0, 7))
                    0:       bus.in_mask = '0;
                    1:       bus.in_mask = ALL;
                    default: bus.in_mask = N'($urandom);
                endcase
            end
            bus.out_ready = N'($urandom | $urandom);
            settle();
            if (bus.in_valid && bus.in_ready) begin
                sent++;
                advance();
                bus.in_valid = 1'b0;
            end else begin
                advance();
            end
            cyc++;
        end
        vecs++;
        if (sent < 1000) begin
            errs++; $display("FAIL random_timeout sent %0d exp 1000", sent);
        end
        drain(8);
        for (int i = 0; i < int'(N); i++) begin
            vecs++;
            if (sbq[i].size() != 0) begin
                errs++; $display("FAIL random_lost sink %0d left %0d exp 0", i, sbq[i].size());
            end
        end
    endtask

    task automatic test_single_sink();
        for (int c = 0; c < 3; c++) begin
            sbus.in_valid  = (c == 0);
            sbus.in_data   = 8'h7E;
            sbus.in_mask   = 1'b1;
            sbus.out_ready = 1'b1;
            settle();
            vecs++;
            if (sbus.out_valid !== (c == 1)) begin
                errs++; $display("FAIL n1_valid cyc %0d got %b exp %b", c, sbus.out_valid, (c == 1));
            end
            if (c == 0) begin
                vecs++;
                if (sbus.in_ready !== 1'b1) begin errs++; $display("FAIL n1_ready got %b exp 1", sbus.in_ready); end
            end
            if (c == 1) begin
                vecs++;
                if (sbus.out_data !== 8'h7E) begin errs++; $display("FAIL n1_data got %h exp 7e", sbus.out_data); end
            end
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_mask    = '0;
        bus.out_ready  = ALL;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.in_mask   = '0;
        sbus.out_ready = 1'b1;
        test_reset();
        test_single();
        drain(3);
        test_back_to_back();
        drain(3);
        test_mask();
        drain(3);
        test_reset_midflight();
        drain(3);
        test_random();
        test_single_sink();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
